dmem_responder: RTL and testbench

- Memory-side responder for the CPU data-memory port; the target end of the load/store path that the pipeline drives.
- Accepts one load or store request at a time over a valid/ready handshake.
- Services each request after a fixed, configurable latency and returns the result on a valid/ready response channel.
- Performs RV32 byte/half/word lane selection and load extension, and flags misaligned accesses, so the core can be tested against multi-cycle memory.

---
 rtl/dmem_responder.sv | 183 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed access latency,
// RV32 lane select / load extension, misalignment and illegal-funct3 errors.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e        r_state;
    logic [31:0]   r_cnt;
    logic          r_write;
    logic [AW+1:0] r_addr;
    logic [2:0]    r_funct3;
    logic [31:0]   r_wdata;
    logic          r_req_ready;
    logic          r_resp_valid;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic [31:0]   w_word;
    logic          w_legal;
    logic          w_aligned;
    logic          w_err;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [31:0]   w_store_word;
    logic          w_fire;
    logic          w_unused_addr;

    // Upper address bits are ignored so addresses wrap modulo the array size.
    assign w_unused_addr = ^req_addr[31:AW+2];

    assign w_idx  = r_addr[AW+1:2];
    assign w_lane = r_addr[1:0];
    assign w_word = r_mem[w_idx];
    assign w_fire = (r_state == StBusy) && (r_cnt == 32'd0);

    always_comb begin
        w_legal = 1'b0;
        case (r_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !r_write;
            default:                w_legal = 1'b0;
        endcase
        w_aligned = 1'b1;
        case (r_funct3[1:0])
            2'b01:   w_aligned = !w_lane[0];
            2'b10:   w_aligned = (w_lane == 2'b00);
            default: w_aligned = 1'b1;
        endcase
        w_err = !w_legal || !w_aligned;
    end

    always_comb begin
        w_byte = w_word[7:0];
        case (w_lane)
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
        w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
        w_load = w_word;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    always_comb begin
        w_store_word = w_word;
        case (r_funct3[1:0])
            2'b00: begin
                case (w_lane)
                    2'd0: w_store_word[7:0]   = r_wdata[7:0];
                    2'd1: w_store_word[15:8]  = r_wdata[7:0];
                    2'd2: w_store_word[23:16] = r_wdata[7:0];
                    2'd3: w_store_word[31:24] = r_wdata[7:0];
                    default: w_store_word = w_word;
                endcase
            end
            2'b01: begin
                if (w_lane[1]) begin
                    w_store_word[31:16] = r_wdata[15:0];
                end else begin
                    w_store_word[15:0] = r_wdata[15:0];
                end
            end
            2'b10:   w_store_word = r_wdata;
            default: w_store_word = w_word;
        endcase
    end

    // Array is not reset; reset forces IDLE so an aborted request never commits.
    always_ff @(posedge clk) begin
        if (w_fire && r_write && !w_err) begin
            r_mem[w_idx] <= w_store_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_cnt        <= 32'd0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_funct3     <= 3'd0;
            r_wdata      <= 32'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid && r_req_ready) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr[AW+1:0];
                        r_funct3    <= req_funct3;
                        r_wdata     <= req_wdata;
                        r_cnt       <= 32'(LATENCY - 1);
                        r_req_ready <= 1'b0;
                        r_state     <= StBusy;
                    end
                end
                StBusy: begin
                    if (r_cnt == 32'd0) begin
                        r_resp_valid <= 1'b1;
                        r_err        <= w_err;
                        r_rdata      <= (w_err || r_write) ? 32'd0 : w_load;
                        r_state      <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_rdata      <= 32'd0;
                        r_err        <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= StIdle;
                    end
                end
                default: begin
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_state      <= StIdle;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 2, 1, 4) driven in lockstep,
// checked by a scoreboard against a byte-level reference memory.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int NI = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NI-1:0]   req_valid;
    logic [NI-1:0]   req_ready;
    logic [NI-1:0]   resp_valid;
    logic [NI-1:0]   resp_ready;
    logic [NI-1:0]   resp_err;
    logic            req_write;
    logic [31:0]     req_addr;
    logic [2:0]      req_funct3;
    logic [31:0]     req_wdata;
    logic [31:0]     resp_rdata [NI];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat_of [NI] = '{2, 1, 4};
    logic [32:0] exp_q [$];
    int rd_ptr [NI];
    logic [31:0] ref_mem [DEPTH];

    genvar g;
    for (g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(DEPTH),
            .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write),
            .req_addr  (req_addr),
            .req_funct3(req_funct3),
            .req_wdata (req_wdata),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s inst=%0d: got %h want %h (cycle %0d)", name, inst, act, want, cyc);
        end
    endtask

    // Reference: byte-addressed memory, size = 1 << funct3[1:0] bytes.
    task automatic ref_op(input bit w, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int idx;
        int lane;
        int nbytes;
        logic legal;
        logic [31:0] mask;
        logic [31:0] val;
        idx    = int'((a >> 2) % DEPTH);
        lane   = int'(a % 4);
        nbytes = 1 << f3[1:0];
        legal  = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        e      = !legal || ((lane % nbytes) != 0);
        rd     = 32'd0;
        if (!e) begin
            if (w) begin
                for (int b = 0; b < nbytes; b++) begin
                    ref_mem[idx][8*(lane+b) +: 8] = wd[8*b +: 8];
                end
            end else begin
                mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
                val  = (ref_mem[idx] >> (8 * lane)) & mask;
                if (!f3[2] && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
                rd = val;
            end
        end
    endtask

    task automatic check_reset(input string name);
        for (int i = 0; i < NI; i++) begin
            check({name, "_req_ready"}, i, 32'(req_ready[i]), 32'd1);
            check({name, "_resp_valid"}, i, 32'(resp_valid[i]), 32'd0);
            check({name, "_rdata"}, i, resp_rdata[i], 32'd0);
            check({name, "_err"}, i, 32'(resp_err[i]), 32'd0);
        end
    endtask

    // Monitor: latency, hold stability, idle-after-handshake, scoreboard compare.
    initial begin
        logic prev_v [NI];
        logic prev_hs [NI];
        logic pend [NI];
        logic prev_e [NI];
        logic [31:0] prev_rd [NI];
        int acc_cyc [NI];
        logic [32:0] ex;
        for (int i = 0; i < NI; i++) begin
            prev_v[i] = 0; prev_hs[i] = 0; pend[i] = 0; acc_cyc[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (rst) begin
                    prev_v[i] = 0; prev_hs[i] = 0; pend[i] = 0;
                end else begin
                    if (prev_hs[i]) begin
                        check("idle_after_hs", i, {30'd0, req_ready[i], resp_valid[i]}, 32'h2);
                    end else if (prev_v[i]) begin
                        check("hold_valid", i, 32'(resp_valid[i]), 32'd1);
                        check("hold_rdata", i, resp_rdata[i], prev_rd[i]);
                        check("hold_err", i, 32'(resp_err[i]), 32'(prev_e[i]));
                    end
                    if (resp_valid[i]) check("ready_in_resp", i, 32'(req_ready[i]), 32'd0);
                    if (resp_valid[i] && !prev_v[i]) begin
                        if (!pend[i]) begin
                            total++; bad++;
                            $display("FAIL unexpected_resp inst=%0d: got resp_valid=1 want 0", i);
                        end else begin
                            check("latency", i, 32'(cyc - acc_cyc[i]), 32'(lat_of[i]));
                        end
                        pend[i] = 0;
                    end
                    if (req_valid[i] && req_ready[i]) begin
                        pend[i] = 1;
                        acc_cyc[i] = cyc + 1;
                    end
                    if (resp_valid[i] && resp_ready[i]) begin
                        if (rd_ptr[i] >= exp_q.size()) begin
                            total++; bad++;
                            $display("FAIL extra_resp inst=%0d: got response want none", i);
                        end else begin
                            ex = exp_q[rd_ptr[i]];
                            check("rdata", i, resp_rdata[i], ex[31:0]);
                            check("err", i, 32'(resp_err[i]), 32'(ex[32]));
                        end
                        rd_ptr[i]++;
                    end
                    prev_v[i]  = resp_valid[i];
                    prev_hs[i] = resp_valid[i] && resp_ready[i];
                    prev_rd[i] = resp_rdata[i];
                    prev_e[i]  = resp_err[i];
                end
            end
        end
    end

    // Issue one request to every instance, then wait for all responses with
    // random backpressure and junk on req_* while busy.
    task automatic issue(input bit w, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, input bit hold);
        logic [31:0] rd;
        logic e;
        int held [NI];
        bit all_done;
        bit done;
        int n;
        ref_op(w, a, f3, wd, rd, e);
        exp_q.push_back({e, rd});
        @(posedge clk);
        #1;
        req_write  = w;
        req_addr   = a;
        req_funct3 = f3;
        req_wdata  = wd;
        req_valid  = '1;
        resp_ready = NI'($urandom);
        @(posedge clk);
        #1;
        n = 0;
        for (int i = 0; i < NI; i++) held[i] = 0;
        forever begin
            all_done = 1;
            for (int i = 0; i < NI; i++) if (rd_ptr[i] != exp_q.size()) all_done = 0;
            if (all_done) break;
            if (n >= 80) begin
                total++; bad++;
                $display("FAIL timeout: got no response within 80 cycles want one");
                break;
            end
            for (int i = 0; i < NI; i++) begin
                done = (rd_ptr[i] == exp_q.size());
                if (hold && resp_valid[i] && held[i] < 5) begin
                    resp_ready[i] = 1'b0;
                    held[i]++;
                end else begin
                    resp_ready[i] = 1'($urandom);
                end
                if (done || (resp_valid[i] && resp_ready[i])) req_valid[i] = 1'b0;
                else req_valid[i] = hold ? 1'b1 : 1'($urandom);
            end
            req_write  = 1'($urandom);
            req_addr   = $urandom;
            req_funct3 = 3'($urandom);
            req_wdata  = $urandom;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid  = '0;
        resp_ready = '0;
    endtask

    initial begin
        logic [31:0] a;
        int idx;
        for (int i = 0; i < NI; i++) rd_ptr[i] = 0;
        req_valid  = '0;
        resp_ready = '0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_funct3 = 3'd0;
        req_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), 3'b010, $urandom, 1'b0);

        issue(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 32'h10, 3'b010, 32'd0, 1'b0);
        issue(1'b1, 32'h11, 3'b000, 32'h0000_00A5, 1'b0);
        issue(1'b0, 32'h10, 3'b010, 32'd0, 1'b0);
        issue(1'b0, 32'h11, 3'b000, 32'd0, 1'b0);
        issue(1'b0, 32'h11, 3'b100, 32'd0, 1'b0);
        issue(1'b1, 32'h12, 3'b001, 32'h0000_8001, 1'b0);
        issue(1'b0, 32'h12, 3'b001, 32'd0, 1'b0);
        issue(1'b0, 32'h12, 3'b101, 32'd0, 1'b0);
        issue(1'b0, 32'h11, 3'b001, 32'd0, 1'b0);
        issue(1'b1, 32'h11, 3'b001, 32'h0000_FFFF, 1'b0);
        issue(1'b0, 32'h10, 3'b010, 32'd0, 1'b1);
        issue(1'b0, 32'(4 * DEPTH + 32'h10), 3'b010, 32'd0, 1'b0);
        issue(1'b1, 32'h13, 3'b010, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 32'h10, 3'b011, 32'd0, 1'b0);
        issue(1'b1, 32'h10, 3'b100, 32'h1111_1111, 1'b0);
        issue(1'b0, 32'h10, 3'b010, 32'd0, 1'b0);

        // Reset during BUSY: no write, no response.
        @(posedge clk);
        #1;
        req_write  = 1'b1;
        req_addr   = 32'h20;
        req_funct3 = 3'b010;
        req_wdata  = 32'h1234_5678;
        req_valid  = '1;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset("busy_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 32'h20, 3'b010, 32'd0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            idx = int'($urandom_range(0, 15));
            a = ($urandom & 32'hFFFF_F000) | 32'(idx << 2) | 32'($urandom_range(0, 3));
            issue(1'($urandom), a, 3'($urandom), $urandom, (k % 10) == 5);
        end

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
